// File: rtl/itype_issue_writeback.sv
// I-type ALU front/back end: fetch, decode, operand issue, writeback, trap.
// Owns the integer register file; the ALU itself sits outside this block.
module itype_issue_writeback #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter logic [6:0]  INSTR_ALU_OPCODE = 7'b0010011
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    output logic [6:0]  opcode,
    output logic [2:0]  subfunction_3,
    output logic [31:0] input_register_value,
    output logic [31:0] itype_immediate,
    input  logic        alu_active,
    input  logic        decoding_error,
    input  logic [31:0] result_to_write_rd,
    output logic        halted,
    output logic [31:0] trap_pc,
    output logic [31:0] retired_count,
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] regs [1:31];
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic        take;
    logic        retire;

    assign rs1        = instr[19:15];
    assign rd         = instr[11:7];
    assign rs1_val    = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign instr_addr = pc;

    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : regs[dbg_reg_addr];

    // A fetch is only accepted once the request is actually visible
    assign take = (state == S_FETCH) && instr_req && instr_valid;

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (take) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (instr[6:0] == INSTR_ALU_OPCODE) state_nx = S_EXECUTE;
                else state_nx = S_TRAP;
            end
            S_EXECUTE: begin
                state_nx = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (decoding_error) begin
                    state_nx = S_TRAP;
                end else if (alu_active) begin
                    state_nx = S_FETCH;
                    retire   = 1'b1;
                end
            end
            S_TRAP: begin
                state_nx = S_TRAP;
            end
            default: begin
                state_nx = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= S_FETCH;
            pc                   <= RESET_PC;
            instr                <= '0;
            instr_req            <= 1'b0;
            opcode               <= '0;
            subfunction_3        <= '0;
            input_register_value <= '0;
            itype_immediate      <= '0;
            halted               <= 1'b0;
            trap_pc              <= '0;
            retired_count        <= '0;
        end else begin
            state     <= state_nx;
            instr_req <= (state_nx == S_FETCH);
            // Opcode is live only in EXECUTE so the ALU fires exactly once
            opcode    <= (state_nx == S_EXECUTE) ? INSTR_ALU_OPCODE : 7'd0;
            if (take) begin
                instr <= instr_data;
            end
            if (state == S_DECODE && state_nx == S_EXECUTE) begin
                subfunction_3        <= instr[14:12];
                input_register_value <= rs1_val;
                itype_immediate      <= {{20{instr[31]}}, instr[31:20]};
            end
            if (retire) begin
                pc            <= pc + 32'd4;
                retired_count <= retired_count + 32'd1;
            end
            if (state != S_TRAP && state_nx == S_TRAP) begin
                halted  <= 1'b1;
                trap_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (retire && rd != 5'd0) begin
            regs[rd] <= result_to_write_rd;
        end
    end

endmodule

// File: tb/tb_itype_issue_writeback.sv
// Bench for itype_issue_writeback: ALU stub, fetch driver, reference model
// and a per-cycle compare process.
module tb_itype_issue_writeback;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_data = 32'd0;
    logic [6:0]  opcode;
    logic [2:0]  subfunction_3;
    logic [31:0] input_register_value;
    logic [31:0] itype_immediate;
    logic        alu_active;
    logic        decoding_error;
    logic [31:0] result_to_write_rd;
    logic        halted;
    logic [31:0] trap_pc;
    logic [31:0] retired_count;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_reg_data;

    logic        dbg_force = 1'b0;
    logic [4:0]  dbg_sel = 5'd0;
    logic [4:0]  dbg_rand = 5'd0;
    assign dbg_reg_addr = dbg_force ? dbg_sel : dbg_rand;

    always #5 clk = ~clk;

    itype_issue_writeback dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .instr_req            (instr_req),
        .instr_addr           (instr_addr),
        .instr_valid          (instr_valid),
        .instr_data           (instr_data),
        .opcode               (opcode),
        .subfunction_3        (subfunction_3),
        .input_register_value (input_register_value),
        .itype_immediate      (itype_immediate),
        .alu_active           (alu_active),
        .decoding_error       (decoding_error),
        .result_to_write_rd   (result_to_write_rd),
        .halted               (halted),
        .trap_pc              (trap_pc),
        .retired_count        (retired_count),
        .dbg_reg_addr         (dbg_reg_addr),
        .dbg_reg_data         (dbg_reg_data)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_fn(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] imm);
        case (f3)
            3'd0: return a + imm;
            3'd1: return a << imm[4:0];
            3'd2: return {31'd0, $signed(a) < $signed(imm)};
            3'd3: return {31'd0, a < imm};
            3'd4: return a ^ imm;
            3'd5: return imm[10] ? 32'($signed(a) >>> imm[4:0]) : a >> imm[4:0];
            3'd6: return a | imm;
            default: return a & imm;
        endcase
    endfunction

    function automatic bit alu_bad(input logic [2:0] f3, input logic [31:0] imm);
        if (f3 == 3'd1) return imm[11:5] != 7'd0;
        if (f3 == 3'd5) return imm[11:5] != 7'd0 && imm[11:5] != 7'h20;
        return 1'b0;
    endfunction

    // ALU stand-in: registered result, sticky illegal flag
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_active         <= 1'b0;
            decoding_error     <= 1'b0;
            result_to_write_rd <= 32'd0;
        end else begin
            alu_active <= (opcode == 7'h13);
            if (opcode == 7'h13) begin
                result_to_write_rd <= alu_fn(subfunction_3, input_register_value,
                                             itype_immediate);
                if (alu_bad(subfunction_3, itype_immediate))
                    decoding_error <= 1'b1;
            end
        end
    end

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] m_trap_pc;
    bit          m_halted;
    bit          m_exp_legal;
    logic [2:0]  m_exp_f3;
    logic [31:0] m_exp_imm;
    logic [31:0] m_exp_rs1v;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0;
        m_ret = 32'd0;
        m_trap_pc = 32'd0;
        m_halted = 1'b0;
        m_exp_legal = 1'b0;
    endtask

    task automatic model_apply(input logic [31:0] ins);
        logic [31:0] imm;
        logic [31:0] r;
        imm = {{20{ins[31]}}, ins[31:20]};
        m_exp_legal = (ins[6:0] == 7'h13);
        m_exp_f3 = ins[14:12];
        m_exp_imm = imm;
        m_exp_rs1v = m_regs[ins[19:15]];
        if (!m_exp_legal || alu_bad(ins[14:12], imm)) begin
            m_halted = 1'b1;
            m_trap_pc = m_pc;
        end else begin
            r = alu_fn(ins[14:12], m_regs[ins[19:15]], imm);
            if (ins[11:7] != 5'd0) m_regs[ins[11:7]] = r;
            m_pc = m_pc + 32'd4;
            m_ret = m_ret + 32'd1;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (instr_req) begin
                chk("fetch_pc", instr_addr, m_pc);
                chk("fetch_retired", retired_count, m_ret);
                chk("fetch_not_expected_halt", {31'd0, m_halted}, 32'd0);
                chk("fetch_halted", {31'd0, halted}, 32'd0);
                chk("fetch_dbg", dbg_reg_data, m_regs[dbg_reg_addr]);
            end
            if (halted) begin
                chk("halt_expected", {31'd0, m_halted}, 32'd1);
                chk("trap_pc", trap_pc, m_trap_pc);
                chk("halt_pc", instr_addr, m_trap_pc);
                chk("halt_retired", retired_count, m_ret);
                chk("halt_req", {31'd0, instr_req}, 32'd0);
                chk("halt_dbg", dbg_reg_data, m_regs[dbg_reg_addr]);
            end
            if (opcode != 7'd0) begin
                chk("exec_opcode", {25'd0, opcode}, 32'h13);
                chk("exec_legal", {31'd0, m_exp_legal}, 32'd1);
                chk("exec_f3", {29'd0, subfunction_3}, {29'd0, m_exp_f3});
                chk("exec_imm", itype_immediate, m_exp_imm);
                chk("exec_rs1", input_register_value, m_exp_rs1v);
            end
            dbg_rand = 5'($urandom_range(0, 31));
        end
    end

    task automatic dbg_chk(input string name, input logic [4:0] a,
                           input logic [31:0] exp);
        dbg_force = 1'b1;
        dbg_sel = a;
        #1;
        chk(name, dbg_reg_data, exp);
        dbg_force = 1'b0;
    endtask

    task automatic do_reset(input bit junk);
        reset_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("rst_req", {31'd0, instr_req}, 32'd0);
        chk("rst_opcode", {25'd0, opcode}, 32'd0);
        chk("rst_f3", {29'd0, subfunction_3}, 32'd0);
        chk("rst_rs1v", input_register_value, 32'd0);
        chk("rst_imm", itype_immediate, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_trap_pc", trap_pc, 32'd0);
        chk("rst_retired", retired_count, 32'd0);
        chk("rst_pc", instr_addr, 32'd0);
        dbg_chk("rst_x1", 5'd1, 32'd0);
        dbg_chk("rst_x2", 5'd2, 32'd0);
        model_reset();
        if (junk) begin
            instr_valid = 1'b1;
            instr_data = 32'h0000_0033;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("first_req", {31'd0, instr_req}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] ins, input int dly, output int t_req);
        int n;
        n = 0;
        t_req = -1;
        while (!instr_req && !halted && n < 40) begin
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b1;
                instr_data = 32'h0000_0033;
            end else begin
                instr_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        instr_valid = 1'b0;
        if (!instr_req) begin
            chk("fetch_wait", {31'd0, instr_req}, 32'd1);
            return;
        end
        t_req = cyc;
        for (int i = 0; i < dly; i++) begin
            @(posedge clk);
            #1;
            chk("addr_stable", instr_addr, m_pc);
            chk("req_held", {31'd0, instr_req}, 32'd1);
        end
        instr_valid = 1'b1;
        instr_data = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_data = $urandom;
        model_apply(ins);
        chk("req_drop", {31'd0, instr_req}, 32'd0);
    endtask

    task automatic wait_req(output int t);
        int n;
        n = 0;
        while (!instr_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wb_done", {31'd0, instr_req}, 32'd1);
        t = cyc;
    endtask

    task automatic wait_halt();
        int n;
        n = 0;
        while (!halted && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("halt_seen", {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_exec();
        int n;
        n = 0;
        while (opcode == 7'd0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("exec_seen", {31'd0, opcode != 7'd0}, 32'd1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  opc;
        int          r;
        f3 = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        opc = 7'h13;
        if (f3 == 3'd1) imm[11:5] = 7'd0;
        if (f3 == 3'd5) imm[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'd0;
        r = $urandom_range(0, 79);
        if (r == 0) begin
            f3 = 3'd5;
            imm[11:5] = 7'h01;
        end else if (r == 1) begin
            opc = 7'h33;
        end
        return {imm, 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)), opc};
    endfunction

    initial begin
        int t0;
        int t1;
        model_reset();
        #2;
        do_reset(1'b1);

        fetch(32'h0050_0093, 0, t0);
        wait_req(t1);
        chk("latency", 32'(t1 - t0), 32'd4);
        dbg_chk("x1_is_5", 5'd1, 32'd5);
        chk("pc_4", instr_addr, 32'd4);
        chk("ret_1", retired_count, 32'd1);

        fetch(32'hFFF0_8113, 0, t0);
        wait_exec();
        chk("imm_neg1", itype_immediate, 32'hFFFF_FFFF);
        chk("rs1v_5", input_register_value, 32'd5);
        wait_req(t1);
        dbg_chk("x2_is_4", 5'd2, 32'd4);
        chk("model_x2", m_regs[2], 32'd4);
        chk("pc_8", instr_addr, 32'd8);
        chk("ret_2", retired_count, 32'd2);

        fetch(32'h0070_0013, 0, t0);
        wait_req(t1);
        dbg_chk("x0_is_0", 5'd0, 32'd0);
        chk("pc_12", instr_addr, 32'd12);
        chk("ret_3", retired_count, 32'd3);

        fetch(32'h0210_D193, 0, t0);
        wait_halt();
        chk("alu_trap_pc", trap_pc, 32'd12);
        dbg_chk("x3_unchanged", 5'd3, 32'd0);
        dbg_chk("x1_kept", 5'd1, 32'd5);
        chk("alu_trap_ret", retired_count, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("trap_frozen_pc", instr_addr, 32'd12);

        do_reset(1'b0);
        fetch(32'h0000_0033, 1, t0);
        wait_halt();
        chk("rtype_trap_pc", trap_pc, 32'd0);
        chk("rtype_ret", retired_count, 32'd0);
        chk("rtype_opcode", {25'd0, opcode}, 32'd0);

        do_reset(1'b0);
        fetch(32'h0090_0093, 0, t0);
        wait_req(t1);
        dbg_chk("x1_is_9", 5'd1, 32'd9);
        fetch(32'h0010_8113, 3, t0);
        wait_exec();
        do_reset(1'b0);
        chk("restart_pc", instr_addr, 32'd0);

        for (int k = 0; k < 150; k++) begin
            if (m_halted) break;
            fetch(rand_instr(), $urandom_range(0, 3), t0);
        end
        if (m_halted) wait_halt();
        else wait_req(t1);
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/itype_issue_writeback.md
Name: itype_issue_writeback

Overview:
- Front and back end for the I-type ALU. It drives the ALU's inputs and consumes its outputs.
- Fetch side: fetches 32-bit instructions over a req/valid handshake, then decodes them.
- Operand side: owns the 32x32 integer register file. It reads rs1, sign-extends the I-immediate and presents the operand fields to the ALU for exactly one cycle.
- Writeback side: collects the ALU result, writes rd, advances the PC and traps on illegal encodings.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INSTR_ALU_OPCODE, 7'b0010011, the only opcode issued to the ALU. Any other opcode traps.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- instr_req  output  1  fetch request, held high until instr_valid
- instr_addr  output  32  fetch address (= pc), stable while instr_req high
- instr_valid  input  1  instr_data valid this cycle
- instr_data  input  32  fetched instruction word
- opcode  output  7  to ALU, instr[6:0] during EXECUTE, else 7'b0
- subfunction_3  output  3  to ALU, instr[14:12]
- input_register_value  output  32  to ALU, rs1 value (x0 reads 0)
- itype_immediate  output  32  to ALU, sign-extended instr[31:20]
- alu_active  input  1  ALU result valid (registered in ALU)
- decoding_error  input  1  ALU illegal funct3/funct7 flag
- result_to_write_rd  input  32  ALU result
- halted  output  1  core stopped in TRAP
- trap_pc  output  32  pc of trapping instruction
- retired_count  output  32  instructions written back
- dbg_reg_addr  input  5  debug register-file read address
- dbg_reg_data  output  32  combinational read of regfile[dbg_reg_addr] (0 for x0)

Behaviour:
- Reset (async, reset_n=0), all forced immediately:
  - state=FETCH, pc=RESET_PC, all 31 registers=0.
  - instr_req=0, opcode=0, subfunction_3=0, input_register_value=0, itype_immediate=0.
  - halted=0, trap_pc=0, retired_count=0.
  - First edge after release raises instr_req.
- FETCH:
  - instr_req=1, instr_addr=pc.
  - On an edge with instr_valid=1: latch instr_data into the instruction register and go to DECODE.
  - instr_valid while instr_req=0 is ignored.
- DECODE (1 cycle):
  - If instr[6:0] != INSTR_ALU_OPCODE, go to TRAP.
  - Otherwise register rs1 value (x0 gives 0), sign-extended immediate and funct3 into the ALU-facing outputs, then go to EXECUTE.
- EXECUTE (1 cycle):
  - opcode=INSTR_ALU_OPCODE is presented, so the ALU samples it on the closing edge.
  - Go to WRITEBACK.
  - Opcode is driven to 0 in every other state, so alu_active deasserts one cycle after WRITEBACK.
- WRITEBACK:
  - If decoding_error=1 (checked before alu_active), go to TRAP with no write.
  - Else if alu_active=1:
    - if rd != 0, write result_to_write_rd to regfile[rd];
    - pc <= pc+4 (32-bit wrap, FFFF_FFFC -> 0);
    - retired_count <= retired_count+1 (wraps);
    - go to FETCH.
  - Else wait; no timeout.
- TRAP:
  - halted=1, trap_pc=pc, instr_req=0.
  - pc and registers are frozen.
  - Only reset exits.
- Latency: minimum 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK) when instr_valid is answered in the request cycle; each fetch wait cycle adds 1.
- Register hazards: none. Writeback completes before the next DECODE reads rs1, so back-to-back dependent instructions see the new value.
- Writes to x0 are discarded, but the instruction still retires.
- Shift legality (imm[11:5]) is judged by the ALU, not by this block.
- The ALU's decoding_error is sticky, so recovery from TRAP requires reset.

Test Plan:
- Reset, then instr 0x00500093 (ADDI x1,x0,5) with instr_valid in the request cycle -> x1=5 via dbg port, pc=4, retired_count=1, next instr_req exactly 4 cycles after the first.
- Follow with 0xFFF08113 (ADDI x2,x1,-1) -> itype_immediate=FFFF_FFFF, input_register_value=5 in EXECUTE, x2=4, pc=8, retired_count=2.
- 0x00700013 (ADDI x0,x0,7) -> dbg read of x0=0, retired_count increments, pc+4.
- 0x00000033 (R-type opcode) -> TRAP in DECODE, halted=1, trap_pc=pc, opcode output never nonzero, no register changes.
- 0x0210D193 (SRL x3,x1,1 with funct7=1) -> ALU flags decoding_error, halted=1, x3 unchanged, retired_count unchanged.
- instr_valid delayed 3 cycles, with reset_n pulsed low mid-EXECUTE on a second run -> instr_addr stable during the wait; reset immediately clears registers, pc=RESET_PC and halted=0, and fetch restarts at RESET_PC.
